// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states,
// the memory-mapped display/switch address and default geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [15:0] MMIO_ADDR           = 16'hFFFF;
  localparam int          DEFAULT_ADDR_W      = 8;
  localparam int          DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous 16-bit RAM of 2^ADDR_W words with a registered,
// enable-gated read port (the output holds between reads).
module mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem_q [2**ADDR_W];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: on-chip RAM plus optional MMIO at 16'hFFFF
// (switch readback / Hex_Out display), enabled by MEM_RESPONDER_MMIO_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset_al,
  input  logic        Req,
  input  logic        WE,
  input  logic [15:0] Addr,
  input  logic [15:0] WData,
  input  logic [15:0] Switches,
  output logic [15:0] RData,
  output logic        Ready,
  output logic        Busy,
  output logic [15:0] Hex_Out
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        src_ram_q, src_ram_d;
  logic [15:0] side_q, side_d;

  logic        resp, ram_hit, ram_we, ram_re;
  logic [15:0] ram_rdata;

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (Req) begin
        cnt_d   = WAIT_LD;
        state_d = (WAIT_LD == 4'd0) ? RESP : WAIT;
      end
      // Leave WAIT on the edge that brings the counter to zero.
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp    = (state_q == RESP);
    Busy    = (state_q != IDLE);
    ram_hit = ((addr_q >> ADDR_W) == 16'd0);
    ram_we  = resp && we_q && ram_hit;
    ram_re  = resp && !we_q && ram_hit;
  end

`ifdef MEM_RESPONDER_MMIO_EN
  logic        mmio_hit;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [15:0] hex_q, hex_d;

  assign mmio_hit = (addr_q == MMIO_ADDR);

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
      hex_q     <= 16'h0000;
    end else begin
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
      hex_q     <= hex_d;
    end
  end

  always_comb begin
    hex_d = hex_q;
    if (resp && we_q && mmio_hit) hex_d = wdata_q;
  end

  assign Hex_Out = hex_q;
`else
  logic unused_switches;
  assign unused_switches = ^Switches;
  assign Hex_Out         = 16'h0000;
`endif

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    ready_d   = resp;
    src_ram_d = src_ram_q;
    side_d    = side_q;
    if (state_q == IDLE && Req) begin
      addr_d  = Addr;
      wdata_d = WData;
      we_d    = WE;
    end
    // Non-RAM read data is captured here; RAM data comes from the array's own register.
    if (resp && !we_q) begin
      src_ram_d = ram_hit;
      side_d    = 16'h0000;
`ifdef MEM_RESPONDER_MMIO_EN
      if (mmio_hit) side_d = sw_sync_q;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      src_ram_q <= 1'b0;
      side_q    <= 16'h0000;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      src_ram_q <= src_ram_d;
      side_q    <= side_d;
    end
  end

  mem_array #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign Ready = ready_q;
  assign RData = src_ram_q ? ram_rdata : side_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with zero wait states, checked with immediate assertions.
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset_al;
  logic        Req, WE, Req0, WE0;
  logic [15:0] Addr, WData, Addr0, WData0, Switches;
  logic [15:0] RData, Hex_Out, RData0, Hex_Out0;
  logic        Ready, Busy, Ready0, Busy0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MEM_RESPONDER_MMIO_EN
  localparam logic [15:0] EXP_SW  = 16'h00A5;
  localparam logic [15:0] EXP_HEX = 16'h3C3C;
`else
  localparam logic [15:0] EXP_SW  = 16'h0000;
  localparam logic [15:0] EXP_HEX = 16'h0000;
`endif

  always #5 Clk = ~Clk;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset_al(Reset_al), .Req(Req), .WE(WE), .Addr(Addr),
    .WData(WData), .Switches(Switches), .RData(RData), .Ready(Ready),
    .Busy(Busy), .Hex_Out(Hex_Out)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset_al(Reset_al), .Req(Req0), .WE(WE0), .Addr(Addr0),
    .WData(WData0), .Switches(Switches), .RData(RData0), .Ready(Ready0),
    .Busy(Busy0), .Hex_Out(Hex_Out0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one request on dut, wait (bounded) for Ready, check latency and read data.
  task automatic access(input string tag, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd);
    int cyc;
    Req = 1'b1; WE = we; Addr = a; WData = d;
    step();
    Req = 1'b0;
    cyc = 0;
    while (Ready !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 3);
    if (!we) chk({tag, "_rdata"}, RData, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int readies;
    Reset_al = 1'b0; Req = 1'b0; WE = 1'b0; Addr = 16'h0; WData = 16'h0;
    Req0 = 1'b0; WE0 = 1'b0; Addr0 = 16'h0; WData0 = 16'h0; Switches = 16'h0;
    step(); step();
    chk("rst_rdata", RData, 16'h0000);
    chk("rst_ready", Ready, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_hex", Hex_Out, 16'h0000);
    chk("rst_ready0", Ready0, 1'b0);
    chk("rst_busy0", Busy0, 1'b0);
    Reset_al = 1'b1;
    step();

    // Write with cycle-exact Busy/Ready timing
    Req = 1'b1; WE = 1'b1; Addr = 16'h0010; WData = 16'hBEEF;
    step();
    Req = 1'b0;
    chk("wr_busy_c1", Busy, 1'b1);
    chk("wr_ready_c1", Ready, 1'b0);
    step();
    chk("wr_busy_c2", Busy, 1'b1);
    chk("wr_ready_c2", Ready, 1'b0);
    step();
    chk("wr_busy_c3", Busy, 1'b1);
    chk("wr_ready_c3", Ready, 1'b0);
    step();
    chk("wr_ready_c4", Ready, 1'b1);
    chk("wr_busy_c4", Busy, 1'b0);
    chk("wr_rdata_unchanged", RData, 16'h0000);
    step();
    chk("wr_ready_c5", Ready, 1'b0);

    access("rd_beef", 1'b0, 16'h0010, 16'h0, 16'hBEEF);
    access("wr_0011", 1'b1, 16'h0011, 16'h1111, 16'h0);
    chk("rdata_hold_after_wr", RData, 16'hBEEF);
    access("rd_0011", 1'b0, 16'h0011, 16'h0, 16'h1111);

    // Out-of-range write must not alias onto word 0
    access("wr_0000", 1'b1, 16'h0000, 16'h5A5A, 16'h0);
    access("wr_oor", 1'b1, 16'h0100, 16'h1234, 16'h0);
    access("rd_oor", 1'b0, 16'h0100, 16'h0, 16'h0000);
    access("rd_0000", 1'b0, 16'h0000, 16'h0, 16'h5A5A);

    // MMIO (out-of-range in the default build)
    Switches = 16'h00A5;
    step(); step(); step();
    access("rd_mmio", 1'b0, 16'hFFFF, 16'h0, EXP_SW);
    access("wr_mmio", 1'b1, 16'hFFFF, 16'h3C3C, 16'h0);
    chk("hex_at_ready", Hex_Out, EXP_HEX);

    // Request during WAIT is dropped
    access("wr_0020", 1'b1, 16'h0020, 16'h7777, 16'h0);
    Req = 1'b1; WE = 1'b1; Addr = 16'h0030; WData = 16'hAAAA;
    step();
    Addr = 16'h0020; WData = 16'hDEAD;
    step();
    Req = 1'b0;
    readies = 0;
    for (int i = 0; i < 8; i++) begin
      if (Ready === 1'b1) readies++;
      step();
    end
    chk("busy_ignore_one_ready", readies, 1);
    access("rd_0020", 1'b0, 16'h0020, 16'h0, 16'h7777);
    access("rd_0030", 1'b0, 16'h0030, 16'h0, 16'hAAAA);

    // Reset in the middle of a write
    access("wr_0005", 1'b1, 16'h0005, 16'h0505, 16'h0);
    access("rd_0005", 1'b0, 16'h0005, 16'h0, 16'h0505);
    Req = 1'b1; WE = 1'b1; Addr = 16'h0005; WData = 16'hFFFF;
    step();
    Req = 1'b0;
    step();
    Reset_al = 1'b0;
    #1;
    chk("midrst_ready", Ready, 1'b0);
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_rdata", RData, 16'h0000);
    chk("midrst_hex", Hex_Out, 16'h0000);
    step(); step();
    Reset_al = 1'b1;
    readies = 0;
    for (int i = 0; i < 5; i++) begin
      if (Ready === 1'b1) readies++;
      step();
    end
    chk("midrst_no_ready", readies, 0);
    access("rd_0005_kept", 1'b0, 16'h0005, 16'h0, 16'h0505);

    // Zero wait states: Req held high, new request every two cycles
    Req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a_tab [4];
      logic [15:0] d_tab [4];
      logic        w_tab [4];
      a_tab = '{16'h0040, 16'h0041, 16'h0040, 16'h0041};
      d_tab = '{16'h1357, 16'h2468, 16'h0000, 16'h0000};
      w_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
      WE0 = w_tab[i]; Addr0 = a_tab[i]; WData0 = d_tab[i];
      step();
      chk($sformatf("z_busy_%0d", i), Busy0, 1'b1);
      chk($sformatf("z_noready_%0d", i), Ready0, 1'b0);
      step();
      chk($sformatf("z_ready_%0d", i), Ready0, 1'b1);
      if (i == 2) chk("z_rd_0040", RData0, 16'h1357);
      if (i == 3) chk("z_rd_0041", RData0, 16'h2468);
    end
    Req0 = 1'b0;
    step();
    chk("z_ready_drop", Ready0, 1'b0);
    chk("z_idle", Busy0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
